// File: rtl/cnn_rom_pkg.sv
// Shared types and constants for the CNN layer weight-ROM streamers.
package cnn_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rom_stream_state_t;

    localparam int MAX_READ_LATENCY = 2;

    // Behavioural weight image: channel c of row r holds c*16 + r, offset per layer.
    function automatic logic [31:0] rom_word(input int layer, input int row, input int ch);
        return 32'((layer - 1) * 64 + ch * 16 + row);
    endfunction

endpackage

// File: rtl/rom_bank.sv
// Wide single-port weight ROM: one row of NUM_CHANNELS words per address, fixed read latency.
module rom_bank
    import cnn_rom_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 3,
    parameter int    WORD_SIZE    = 8,
    parameter int    NUM_CHANNELS = 2,
    parameter int    DEPTH        = 2 ** ADDR_WIDTH,
    parameter int    READ_LATENCY = 1,
    parameter string MEM_INIT     = "0_1_0.mif",
    parameter int    LAYER_NUMBER = 1
) (
    input  logic                               clk_i,
    input  logic                               en_i,
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    output logic [NUM_CHANNELS*WORD_SIZE-1:0]  data_o
);

    localparam int DW = NUM_CHANNELS * WORD_SIZE;

`ifdef VIVADO
    xpm_memory_sprom #(
        .ADDR_WIDTH_A      (ADDR_WIDTH),
        .MEMORY_SIZE       (DEPTH * DW),
        .MEMORY_PRIMITIVE  ("block"),
        .MEMORY_INIT_FILE  (MEM_INIT),
        .READ_DATA_WIDTH_A (DW),
        .READ_LATENCY_A    (READ_LATENCY)
    ) u_sprom (
        .clka           (clk_i),
        .ena            (en_i),
        .addra          (addr_i),
        .douta          (data_o),
        .rsta           (1'b0),
        .regcea         (1'b1),
        .injectdbiterra (1'b0),
        .injectsbiterra (1'b0),
        .sleep          (1'b0),
        .dbiterra       (),
        .sbiterra       ()
    );
`else
    logic [DW-1:0] row_word;
    logic [DW-1:0] pipe [READ_LATENCY];

    // A build with no init file name gets a blank ROM.
    always_comb begin
        row_word = '0;
        if (MEM_INIT != "") begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                row_word[c*WORD_SIZE +: WORD_SIZE] =
                    WORD_SIZE'(rom_word(LAYER_NUMBER, int'(addr_i), c));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            pipe[0] <= row_word;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign data_o = pipe[READ_LATENCY-1];
`endif

endmodule

// File: rtl/rom_weight_streamer.sv
// Streams LEN weight rows from a wide ROM as a valid/ready burst, prefetching to hide read latency.
module rom_weight_streamer
    import cnn_rom_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 3,
    parameter int    WORD_SIZE    = 8,
    parameter int    NUM_CHANNELS = 2,
    parameter int    DEPTH        = 2 ** ADDR_WIDTH,
    parameter int    READ_LATENCY = 1,
    parameter string MEM_INIT     = "0_1_0.mif",
    parameter int    LAYER_NUMBER = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic [ADDR_WIDTH-1:0]              start_addr_i,
    input  logic [ADDR_WIDTH:0]                len_i,
    output logic [NUM_CHANNELS*WORD_SIZE-1:0]  data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               busy_o,
    output logic                               done_o,
    output rom_stream_state_t                  state_o
);

    localparam int DW         = NUM_CHANNELS * WORD_SIZE;
    localparam int CW         = ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH = READ_LATENCY + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    rom_stream_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           issue_cnt, accept_cnt, len_eff;
    logic [READ_LATENCY-1:0] rd_vld;
    logic [DW-1:0]           rom_data;
    logic [DW-1:0]           fifo_mem [MAX_READ_LATENCY+1];
    logic [1:0]              wr_ptr, rd_ptr, fifo_cnt;
    logic                    start_ok, issue, push, pop;
    int                      inflight;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    rom_bank #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WORD_SIZE    (WORD_SIZE),
        .NUM_CHANNELS (NUM_CHANNELS),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .MEM_INIT     (MEM_INIT),
        .LAYER_NUMBER (LAYER_NUMBER)
    ) u_rom_bank (
        .clk_i  (clk_i),
        .en_i   (issue),
        .addr_i (addr_q),
        .data_o (rom_data)
    );

    // Handshake: a beat transfers on any cycle with valid_o && ready_i; once valid_o rises,
    // data_o and valid_o hold until that transfer, and ready_i may change freely.
    always_comb begin
        state_nxt = state;
        len_eff   = (len_i == '0) ? DEPTH_C : len_i;
        start_ok  = start_i && (state != RUN);
        valid_o   = (fifo_cnt != 2'd0);
        pop       = valid_o && ready_i;
        push      = rd_vld[READ_LATENCY-1];
        data_o    = valid_o ? fifo_mem[rd_ptr] : '0;
        busy_o    = (state == RUN);
        done_o    = (state == DONE);
        state_o   = state;
        inflight  = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + int'(rd_vld[i]);
        end
        // A slot being popped this cycle is free again by the time new read data lands.
        issue = (state == RUN) && (issue_cnt != '0) &&
                (int'(fifo_cnt) + inflight < FIFO_DEPTH + int'(pop));
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (pop && accept_cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = start_ok ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            rd_vld     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                addr_q     <= start_addr_i;
                issue_cnt  <= len_eff;
                accept_cnt <= len_eff;
            end else begin
                if (issue) begin
                    addr_q    <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (pop) begin
                    accept_cnt <= accept_cnt - 1'b1;
                end
            end
            rd_vld[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_weight_streamer.sv
// Directed bench for rom_weight_streamer: RL=1 and RL=2 two-channel instances plus a four-channel one.
module tb_rom_weight_streamer;
    import cnn_rom_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i = 1'b1;
    logic       start_a = 1'b0, ready_a = 1'b0;
    logic       start_b = 1'b0, ready_b = 1'b0;
    logic [2:0] start_addr = '0;
    logic [3:0] len = '0;

    logic [15:0] data_a, data_b;
    logic [31:0] data_c;
    logic valid_a, busy_a, done_a, valid_b, busy_b, done_b, valid_c, busy_c, done_c;
    rom_stream_state_t state_a, state_b, state_c;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];

    rom_weight_streamer #(.ADDR_WIDTH(3), .WORD_SIZE(8), .NUM_CHANNELS(2), .DEPTH(8),
                          .READ_LATENCY(1)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .start_addr_i(start_addr),
        .len_i(len), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
        .busy_o(busy_a), .done_o(done_a), .state_o(state_a));

    rom_weight_streamer #(.ADDR_WIDTH(3), .WORD_SIZE(8), .NUM_CHANNELS(2), .DEPTH(8),
                          .READ_LATENCY(2)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_b), .start_addr_i(start_addr),
        .len_i(len), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
        .busy_o(busy_b), .done_o(done_b), .state_o(state_b));

    rom_weight_streamer #(.ADDR_WIDTH(3), .WORD_SIZE(8), .NUM_CHANNELS(4), .DEPTH(8),
                          .READ_LATENCY(1)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .start_addr_i(start_addr),
        .len_i(len), .data_o(data_c), .valid_o(valid_c), .ready_i(ready_a),
        .busy_o(busy_c), .done_o(done_c), .state_o(state_c));

    // ROM image: channel c of row k holds 16*c + k, channel 0 in the low byte.
    function automatic logic [31:0] exp_row2(input int k);
        return {16'h0, 8'(16 + k), 8'(k)};
    endfunction

    function automatic logic [31:0] exp_row4(input int k);
        return {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst_a(input int addr, input int l);
        start_addr = 3'(addr);
        len        = 4'(l);
        start_a    = 1'b1;
        step();
        start_a    = 1'b0;
    endtask

    // Expects n consecutive beats on the A and C instances with ready held high.
    task automatic expect_beats_a(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            check("a_valid", {31'h0, valid_a}, 32'h1);
            check("a_data", {16'h0, data_a}, exp_row2((first + i) % 8));
            check("c_data", data_c, exp_row4((first + i) % 8));
            check("a_no_early_done", {31'h0, done_a}, 32'h0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first_valid;
        bit  stall, done_seen;
        logic [15:0] held;

        repeat (2) step();
        check("rst_valid", {31'h0, valid_a}, 32'h0);
        check("rst_busy", {31'h0, busy_a}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_data", {16'h0, data_a}, 32'h0);
        check("rst_state", 32'(state_b), 32'(IDLE));
        reset_i = 1'b0;
        ready_a = 1'b1;

        // Full burst from row 0: first beat two cycles after start, then one per cycle.
        start_burst_a(0, 8);
        check("t1_busy", {31'h0, busy_a}, 32'h1);
        check("t1_lat0", {31'h0, valid_a}, 32'h0);
        step();
        check("t1_lat1", {31'h0, valid_a}, 32'h0);
        step();
        expect_beats_a(0, 8);
        check("t1_done", {31'h0, done_a}, 32'h1);
        check("t1_busy_done", {31'h0, busy_a}, 32'h0);
        check("t1_valid_done", {31'h0, valid_a}, 32'h0);
        step();
        check("t1_done_once", {31'h0, done_a}, 32'h0);
        check("t1_idle", 32'(state_a), 32'(IDLE));

        // Address wrap at DEPTH.
        start_burst_a(6, 4);
        step();
        step();
        expect_beats_a(6, 4);
        check("t2_done", {31'h0, done_a}, 32'h1);
        step();

        // Start while busy is ignored; start in the DONE cycle is taken without a gap.
        start_burst_a(0, 3);
        start_addr = 3'd3;
        start_a    = 1'b1;
        step();
        start_a    = 1'b0;
        step();
        expect_beats_a(0, 3);
        check("t3_done", {31'h0, done_a}, 32'h1);
        start_burst_a(5, 2);
        check("t3_no_gap", 32'(state_a), 32'(RUN));
        step();
        step();
        expect_beats_a(5, 2);
        check("t3_done2", {31'h0, done_a}, 32'h1);
        step();

        // Reset on beat 3 of 8, then a fresh burst restarts at row 0.
        start_burst_a(0, 8);
        step();
        step();
        expect_beats_a(0, 3);
        check("t4_beat3", {16'h0, data_a}, exp_row2(3));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("t4_valid", {31'h0, valid_a}, 32'h0);
        check("t4_busy", {31'h0, busy_a}, 32'h0);
        check("t4_data", {16'h0, data_a}, 32'h0);
        check("t4_c_busy", {31'h0, busy_c}, 32'h0);
        start_burst_a(0, 2);
        step();
        step();
        expect_beats_a(0, 2);
        check("t4_done", {31'h0, done_c}, 32'h1);
        step();

        // len 0 means DEPTH beats; also exercises the four-channel instance.
        start_burst_a(2, 0);
        step();
        check("t5_valid_c", {31'h0, valid_c}, 32'h0);
        step();
        expect_beats_a(2, 8);
        check("t5_done", {31'h0, done_c}, 32'h1);
        step();

        // RL=2 instance under backpressure with ready pattern 1,0,0.
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_row2(k));
        start_addr = 3'd0;
        len        = 4'd5;
        start_b    = 1'b1;
        step();
        start_b     = 1'b0;
        stall       = 1'b0;
        done_seen   = 1'b0;
        first_valid = -1;
        held        = '0;
        for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
            ready_b = (cyc % 3 == 0);
            if (stall) check("b_hold", {15'h0, valid_b, data_b}, {15'h0, 1'b1, held});
            if (done_b) done_seen = 1'b1;
            if (valid_b && first_valid < 0) first_valid = cyc;
            if (valid_b && ready_b) begin
                check("b_beat", {16'h0, data_b},
                      (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
                stall = 1'b0;
            end else if (valid_b) begin
                held  = data_b;
                stall = 1'b1;
            end else begin
                stall = 1'b0;
            end
            step();
        end
        check("b_done_seen", {31'h0, done_seen}, 32'h1);
        check("b_first_valid", 32'(first_valid), 32'd3);
        check("b_all_beats", 32'(exp_q.size()), 32'd0);
        check("b_done_once", {31'h0, done_b}, 32'h0);
        check("b_idle", {31'h0, busy_b}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
